uart_tx_buffer: RTL and testbench

- Transmit-side front-end FIFO that sits directly upstream of uart_controller.
- Accepts bytes from a host or bus over a valid/ready write port and buffers them.
- Drains the buffer one character at a time into the controller's tx_start_i / tx_data_i, pacing itself on tx_busy_o and tx_done_o.
- Decouples bursty producers from the serial line rate.

---
 rtl/uart_tx_buffer.sv | 144 ++++++++++++++
 tb/tb_uart_tx_buffer.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_buffer.sv
// Transmit FIFO in front of uart_controller; launches one character per start/busy/done handshake.
// Define UART_TX_BUF_FLUSH_EN to add flush_i, which clears queued characters but not the in-flight one.
module uart_tx_buffer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
`ifdef UART_TX_BUF_FLUSH_EN
  input  logic                       flush_i,
`endif
  input  logic                       wr_valid_i,
  input  logic [DATA_W-1:0]          wr_data_i,
  output logic                       wr_ready_o,
  input  logic                       drain_en_i,
  input  logic                       tx_busy_i,
  input  logic                       tx_done_i,
  output logic                       tx_start_o,
  output logic [DATA_W-1:0]          tx_data_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       empty_o,
  output logic                       full_o
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   LVL_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0]   LVL_FULL = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT_DONE
  } state_t;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_level;
  logic [ADDR_W:0]   w_level_next;
  logic              r_empty;
  logic              r_full;
  logic              r_tx_start;
  logic [DATA_W-1:0] r_tx_data;
  state_t            r_state;
  logic              w_flush;
  logic              w_wr;
  logic              w_pop;

`ifdef UART_TX_BUF_FLUSH_EN
  assign w_flush = flush_i;
`else
  assign w_flush = 1'b0;
`endif

  // Write acceptance looks only at the registered full flag, so a same-cycle pop cannot make room.
  assign w_wr  = wr_valid_i && !r_full && !w_flush;
  assign w_pop = (r_state == S_IDLE) && drain_en_i && !r_empty && !tx_busy_i && !w_flush;

  always_comb begin
    w_level_next = r_level;
    if (w_flush) begin
      w_level_next = '0;
    end else if (w_wr && !w_pop) begin
      w_level_next = r_level + LVL_ONE;
    end else if (!w_wr && w_pop) begin
      w_level_next = r_level - LVL_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= wr_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
    end else begin
      if (w_flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_wr) begin
          r_wr_ptr <= r_wr_ptr + PTR_ONE;
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
      end
      r_level <= w_level_next;
      r_empty <= (w_level_next == '0);
      r_full  <= (w_level_next == LVL_FULL);
    end
  end

  // tx_data_o is only loaded on a pop, so it stays stable for the whole character.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_tx_start <= 1'b0;
      r_tx_data  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_tx_data  <= r_mem[r_rd_ptr];
            r_tx_start <= 1'b1;
            r_state    <= S_START;
          end
        end
        S_START: begin
          if (tx_busy_i) begin
            r_tx_start <= 1'b0;
            r_state    <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          r_tx_start <= 1'b0;
          if (tx_done_i) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_tx_start <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

  assign wr_ready_o = !r_full;
  assign tx_start_o = r_tx_start;
  assign tx_data_o  = r_tx_data;
  assign level_o    = r_level;
  assign empty_o    = r_empty;
  assign full_o     = r_full;

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Randomized bench for uart_tx_buffer: a queue-based FIFO model plus a simple controller model
// (busy some cycles after start, one-cycle done later) checks every output on every cycle.
module tb_uart_tx_buffer;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              rst_i;
  logic              wr_valid_i;
  logic [DATA_W-1:0] wr_data_i;
  logic              wr_ready_o;
  logic              drain_en_i;
  logic              tx_busy_i;
  logic              tx_done_i;
  logic              tx_start_o;
  logic [DATA_W-1:0] tx_data_o;
  logic [4:0]        level_o;
  logic              empty_o;
  logic              full_o;

  always #5 clk = ~clk;

  uart_tx_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .wr_valid_i (wr_valid_i),
    .wr_data_i  (wr_data_i),
    .wr_ready_o (wr_ready_o),
    .drain_en_i (drain_en_i),
    .tx_busy_i  (tx_busy_i),
    .tx_done_i  (tx_done_i),
    .tx_start_o (tx_start_o),
    .tx_data_o  (tx_data_o),
    .level_o    (level_o),
    .empty_o    (empty_o),
    .full_o     (full_o)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: queued characters, the character on the wire, and the start handshake.
  logic [7:0] q[$];
  logic [7:0] launch_log[$];
  logic [7:0] acc_log[$];
  logic [7:0] data_exp;
  bit         start_exp;
  bit         inflight;
  int         nlaunch;

  // Controller model state.
  int ph;
  int cnt;
  int busy_dly;
  int done_dly;
  bit rand_dly;
  bit c_busy;
  bit c_done;
  bit ext_busy;
  bit spur_done;

  task automatic reset_model();
    q.delete();
    inflight  = 1'b0;
    start_exp = 1'b0;
    data_exp  = 8'h00;
    ph        = 0;
    c_busy    = 1'b0;
    c_done    = 1'b0;
  endtask

  // One clock: drive controller inputs, advance, update the model, compare every output.
  task automatic tick();
    bit         p_rst, p_wr, p_drain, p_busy, p_done, can_launch, acc;
    logic [7:0] p_data;
    int         lv;
    tx_busy_i  = c_busy | ext_busy;
    tx_done_i  = c_done | spur_done;
    p_rst      = rst_i;
    p_wr       = wr_valid_i;
    p_data     = wr_data_i;
    p_drain    = drain_en_i;
    p_busy     = tx_busy_i;
    p_done     = tx_done_i;
    can_launch = !p_rst && p_drain && (q.size() > 0) && !p_busy && !inflight;
    acc        = !p_rst && p_wr && (q.size() < DEPTH);
    @(posedge clk);
    #1;
    if (p_rst) begin
      reset_model();
    end else begin
      if (p_done && inflight && !start_exp) inflight = 1'b0;
      if (p_busy && start_exp) start_exp = 1'b0;
      if (can_launch) begin
        data_exp  = q.pop_front();
        inflight  = 1'b1;
        start_exp = 1'b1;
        nlaunch++;
        launch_log.push_back(data_exp);
        $display("launch data=%02h level_after=%0d", data_exp, q.size() + (acc ? 1 : 0));
      end
      if (acc) begin
        q.push_back(p_data);
        acc_log.push_back(p_data);
        $display("write  data=%02h level_after=%0d", p_data, q.size());
      end
    end
    lv = q.size();
    total += 6;
    if (tx_start_o !== start_exp) begin
      bad++; $display("FAIL tx_start got=%0b want=%0b t=%0t", tx_start_o, start_exp, $time);
    end
    if (tx_data_o !== data_exp) begin
      bad++; $display("FAIL tx_data got=%02h want=%02h t=%0t", tx_data_o, data_exp, $time);
    end
    if (level_o !== lv[4:0]) begin
      bad++; $display("FAIL level got=%0d want=%0d t=%0t", level_o, lv, $time);
    end
    if (empty_o !== (lv == 0)) begin
      bad++; $display("FAIL empty got=%0b want=%0b t=%0t", empty_o, (lv == 0), $time);
    end
    if (full_o !== (lv == DEPTH)) begin
      bad++; $display("FAIL full got=%0b want=%0b t=%0t", full_o, (lv == DEPTH), $time);
    end
    if (wr_ready_o !== (lv != DEPTH)) begin
      bad++; $display("FAIL wr_ready got=%0b want=%0b t=%0t", wr_ready_o, (lv != DEPTH), $time);
    end
    if (p_rst) begin
      ph = 0; c_busy = 1'b0; c_done = 1'b0;
    end else begin
      case (ph)
        0: begin
          c_done = 1'b0;
          if (tx_start_o) begin
            if (rand_dly) begin
              busy_dly = $urandom_range(1, 3);
              done_dly = $urandom_range(1, 8);
            end
            cnt = busy_dly;
            ph  = 1;
          end
        end
        1: begin
          cnt--;
          if (cnt <= 0) begin c_busy = 1'b1; cnt = done_dly; ph = 2; end
        end
        2: begin
          cnt--;
          if (cnt <= 0) begin c_busy = 1'b0; c_done = 1'b1; ph = 3; end
        end
        default: begin c_done = 1'b0; ph = 0; end
      endcase
    end
  endtask

  task automatic wait_empty_idle(input int budget, input string nm);
    int i;
    for (i = 0; i < budget; i++) begin
      if (q.size() == 0 && !inflight && ph == 0) break;
      tick();
    end
    total++;
    if (i >= budget) begin
      bad++; $display("FAIL %s timeout got=level%0d want=empty_idle", nm, q.size());
    end
  endtask

  task automatic wait_char_done(input int budget, input string nm);
    int i;
    for (i = 0; i < budget; i++) begin
      if (!inflight && ph == 0) break;
      tick();
    end
    total++;
    if (i >= budget) begin
      bad++; $display("FAIL %s timeout got=inflight want=idle", nm);
    end
  endtask

  task automatic wait_in_wait_done(input int budget, input string nm);
    int i;
    for (i = 0; i < budget; i++) begin
      if (inflight && !start_exp) break;
      tick();
    end
    total++;
    if (i >= budget) begin
      bad++; $display("FAIL %s timeout got=not_waiting want=wait_done", nm);
    end
  endtask

  task automatic write_byte(input logic [7:0] d);
    wr_valid_i = 1'b1;
    wr_data_i  = d;
    tick();
    wr_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    tick();
    tick();
    total += 4;
    if (level_o !== 5'd0) begin bad++; $display("FAIL reset_level got=%0d want=0", level_o); end
    if (empty_o !== 1'b1 || full_o !== 1'b0) begin
      bad++; $display("FAIL reset_flags got=e%0b f%0b want=e1 f0", empty_o, full_o);
    end
    if (wr_ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b want=1", wr_ready_o); end
    if (tx_start_o !== 1'b0 || tx_data_o !== 8'h00) begin
      bad++; $display("FAIL reset_tx got=s%0b d%02h want=s0 d00", tx_start_o, tx_data_o);
    end
    rst_i = 1'b0;
    tick();
  endtask

  task automatic test_single();
    int start_cycles = 0;
    int i;
    rand_dly = 1'b0; busy_dly = 2; done_dly = 100;
    write_byte(8'h55);
    drain_en_i = 1'b1;
    for (i = 0; i < 300; i++) begin
      tick();
      if (tx_start_o) start_cycles++;
      if (nlaunch > 0 && !inflight && ph == 0) break;
    end
    total += 4;
    if (i >= 300) begin bad++; $display("FAIL single_timeout got=busy want=idle"); end
    if (start_cycles != 3) begin bad++; $display("FAIL single_start_len got=%0d want=3", start_cycles); end
    if (tx_data_o !== 8'h55) begin bad++; $display("FAIL single_data got=%02h want=55", tx_data_o); end
    if (level_o !== 5'd0 || empty_o !== 1'b1) begin
      bad++; $display("FAIL single_level got=%0d want=0", level_o);
    end
    tick();
    drain_en_i = 1'b0;
  endtask

  task automatic test_fill_wrap();
    int i;
    rand_dly = 1'b1;
    drain_en_i = 1'b0;
    launch_log.delete();
    for (int k = 0; k < 16; k++) write_byte(8'(k));
    total += 2;
    if (full_o !== 1'b1 || wr_ready_o !== 1'b0) begin
      bad++; $display("FAIL fill_full got=f%0b r%0b want=f1 r0", full_o, wr_ready_o);
    end
    write_byte(8'hAA);
    if (level_o !== 5'd16) begin bad++; $display("FAIL fill_17th got=%0d want=16", level_o); end
    drain_en_i = 1'b1;
    for (i = 0; i < 500; i++) begin
      if (launch_log.size() >= 4) break;
      tick();
    end
    total++;
    if (i >= 500) begin bad++; $display("FAIL fill_pop4 timeout got=%0d want=4", launch_log.size()); end
    for (int k = 16; k < 20; k++) write_byte(8'(k));
    wait_empty_idle(2000, "fill_drain");
    total++;
    if (launch_log.size() != 20) begin
      bad++; $display("FAIL fill_count got=%0d want=20", launch_log.size());
    end
    for (int k = 0; k < launch_log.size() && k < 20; k++) begin
      total++;
      if (launch_log[k] !== 8'(k)) begin
        bad++; $display("FAIL fill_order[%0d] got=%02h want=%02h", k, launch_log[k], k);
      end
    end
    drain_en_i = 1'b0;
  endtask

  task automatic test_simul();
    rand_dly = 1'b1;
    drain_en_i = 1'b0;
    for (int k = 0; k < 15; k++) write_byte(8'($urandom));
    total++;
    if (level_o !== 5'd15) begin bad++; $display("FAIL simul_setup got=%0d want=15", level_o); end
    drain_en_i = 1'b1;
    write_byte(8'($urandom));
    drain_en_i = 1'b0;
    total++;
    if (level_o !== 5'd15) begin bad++; $display("FAIL simul_wr_pop got=%0d want=15", level_o); end
    wait_char_done(200, "simul_char1");
    write_byte(8'($urandom));
    drain_en_i = 1'b1;
    write_byte(8'($urandom));
    drain_en_i = 1'b0;
    total++;
    if (level_o !== 5'd15) begin bad++; $display("FAIL simul_full_pop got=%0d want=15", level_o); end
    wait_char_done(200, "simul_char2");
    drain_en_i = 1'b1;
    wait_empty_idle(2000, "simul_drain");
    drain_en_i = 1'b0;
  endtask

  task automatic test_async_reset();
    int n0;
    rand_dly = 1'b0; busy_dly = 2; done_dly = 60;
    for (int k = 0; k < 6; k++) write_byte(8'($urandom));
    drain_en_i = 1'b1;
    wait_in_wait_done(100, "arst_reach");
    drain_en_i = 1'b0;
    tick();
    total++;
    if (level_o !== 5'd5) begin bad++; $display("FAIL arst_setup got=%0d want=5", level_o); end
    #2;
    rst_i = 1'b1;
    #1;
    total += 3;
    if (tx_start_o !== 1'b0 || tx_data_o !== 8'h00) begin
      bad++; $display("FAIL arst_tx got=s%0b d%02h want=s0 d00", tx_start_o, tx_data_o);
    end
    if (level_o !== 5'd0) begin bad++; $display("FAIL arst_level got=%0d want=0", level_o); end
    if (empty_o !== 1'b1 || full_o !== 1'b0 || wr_ready_o !== 1'b1) begin
      bad++; $display("FAIL arst_flags got=e%0b f%0b r%0b want=e1 f0 r1", empty_o, full_o, wr_ready_o);
    end
    reset_model();
    tick();
    tick();
    rst_i = 1'b0;
    n0 = nlaunch;
    drain_en_i = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    total++;
    if (nlaunch != n0 || tx_start_o !== 1'b0) begin
      bad++; $display("FAIL arst_no_launch got=%0d want=%0d", nlaunch - n0, 0);
    end
    drain_en_i = 1'b0;
    rand_dly = 1'b1;
  endtask

  task automatic test_drain_pause();
    int n0;
    rand_dly = 1'b1;
    for (int k = 0; k < 3; k++) write_byte(8'($urandom));
    drain_en_i = 1'b1;
    wait_in_wait_done(100, "pause_reach");
    drain_en_i = 1'b0;
    wait_char_done(100, "pause_finish");
    n0 = nlaunch;
    tick();
    spur_done = 1'b1;
    tick();
    spur_done = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    total += 2;
    if (nlaunch != n0) begin bad++; $display("FAIL pause_no_start got=%0d want=0", nlaunch - n0); end
    if (level_o !== 5'd2) begin bad++; $display("FAIL pause_level got=%0d want=2", level_o); end
    ext_busy = 1'b1;
    drain_en_i = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    total++;
    if (nlaunch != n0) begin bad++; $display("FAIL ext_busy_block got=%0d want=0", nlaunch - n0); end
    ext_busy = 1'b0;
    wait_empty_idle(200, "pause_drain");
    total++;
    if (nlaunch != n0 + 2) begin bad++; $display("FAIL pause_total got=%0d want=2", nlaunch - n0); end
    drain_en_i = 1'b0;
  endtask

  task automatic test_random();
    rand_dly = 1'b1;
    launch_log.delete();
    acc_log.delete();
    for (int c = 0; c < 500; c++) begin
      wr_valid_i = ($urandom_range(0, 9) < 6);
      wr_data_i  = 8'($urandom);
      if ($urandom_range(0, 19) == 0) drain_en_i = ~drain_en_i;
      spur_done = (!inflight && ph == 0 && $urandom_range(0, 19) == 0);
      tick();
    end
    wr_valid_i = 1'b0;
    spur_done  = 1'b0;
    drain_en_i = 1'b1;
    wait_empty_idle(2000, "random_drain");
    total++;
    if (launch_log.size() != acc_log.size()) begin
      bad++; $display("FAIL random_count got=%0d want=%0d", launch_log.size(), acc_log.size());
    end
    for (int k = 0; k < launch_log.size() && k < acc_log.size(); k++) begin
      total++;
      if (launch_log[k] !== acc_log[k]) begin
        bad++; $display("FAIL random_order[%0d] got=%02h want=%02h", k, launch_log[k], acc_log[k]);
      end
    end
  endtask

  initial begin
    rst_i      = 1'b1;
    wr_valid_i = 1'b0;
    wr_data_i  = 8'h00;
    drain_en_i = 1'b0;
    tx_busy_i  = 1'b0;
    tx_done_i  = 1'b0;
    ext_busy   = 1'b0;
    spur_done  = 1'b0;
    rand_dly   = 1'b1;
    busy_dly   = 2;
    done_dly   = 3;
    nlaunch    = 0;
    reset_model();
    test_reset();
    test_single();
    test_fill_wrap();
    test_simul();
    test_async_reset();
    test_drain_pause();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
